// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment codes and pin polarity helpers for the scan driver
package sevenseg_pkg;

    // Active-high {g,f,e,d,c,b,a} codes
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_pins(input logic [6:0] code, input logic active_low);
        return active_low ? ~code : code;
    endfunction

    function automatic logic dp_pin(input logic lit, input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// rtl/sevenseg_hex_decoder.sv - combinational hex nibble to active-high segment code
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    always_comb begin
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - multiplexed seven-segment driver with blink, LZ suppression and PWM
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV_WIDTH      = 13,
    parameter int BRIGHT_WIDTH   = 4,
    parameter int BLINK_WIDTH    = 6,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_AL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_AL = (AN_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_AL}};

    logic [DIV_WIDTH-1:0]    prescaler;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_WIDTH-1:0]  frame_cnt;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_lz;

    logic                    tick;
    logic                    frame_end;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_code;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic                    visible;
    logic                    lit;
    logic [BRIGHT_WIDTH-1:0] pwm;
    logic [NUM_DIGITS-1:0]   onehot;

    assign tick      = &prescaler;
    assign frame_end = tick && (idx == LAST_IDX);

    // Snapshot resets blanked so nothing lights before the first frame boundary
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prescaler   <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '1;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            frame_done <= frame_end;
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (frame_end) begin
                frame_cnt   <= frame_cnt + 1'b1;
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_blank  <= blank_in;
                snap_blink  <= blink_in;
                snap_lz     <= lz_suppress;
            end
        end
    end

    assign cur_nibble = snap_digits[4*idx +: 4];

    sevenseg_hex_decoder u_decoder (
        .nibble (cur_nibble),
        .code   (cur_code)
    );

    // Walk down from the top digit; suppression stops at the first non-zero nibble
    always_comb begin
        lz_mask  = '0;
        zero_run = snap_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (snap_digits[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        pwm         = prescaler[DIV_WIDTH-1 -: BRIGHT_WIDTH];
        visible     = !snap_blank[idx]
                   && !(snap_blink[idx] && frame_cnt[BLINK_WIDTH-1])
                   && !lz_mask[idx];
        lit         = visible && (pwm < brightness);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seg <= seg_pins(SEG_BLANK, SEG_AL);
            dp  <= dp_pin(1'b0, SEG_AL);
            an  <= AN_OFF;
        end else begin
            seg <= seg_pins(lit ? cur_code : SEG_BLANK, SEG_AL);
            dp  <= dp_pin(lit && snap_dp[idx], SEG_AL);
            an  <= lit ? (AN_AL ? ~onehot : onehot) : AN_OFF;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb/tb_sevenseg_scan_driver.sv - scoreboard bench for sevenseg_scan_driver
module tb_sevenseg_scan_driver;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int BW = 2;
    localparam int KW = 2;
    localparam int SLOT = 1 << DW;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  blink_in = 4'h0;
    logic        lz_suppress = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    sevenseg_scan_driver #(
        .NUM_DIGITS     (ND),
        .DIV_WIDTH      (DW),
        .BRIGHT_WIDTH   (BW),
        .BLINK_WIDTH    (KW),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          edges = 0;
    logic [6:0]  hex_tab [16];
    logic [15:0] s_digits;
    logic [3:0]  s_dp, s_blank, s_blink;
    logic        s_lz;
    int          m_p, m_slot, m_frame;
    logic        m_on;
    exp_t        m_e, c_e;

    // Number of digit positions shown under leading-zero suppression (at least one)
    function automatic int sig_digits(input logic [15:0] d);
        int n = 1;
        for (int i = 0; i < ND; i++) begin
            if (d[4*i +: 4] != 4'h0) n = i + 1;
        end
        return n;
    endfunction

    // Reference model: outputs after an edge reflect the time position before it
    always @(posedge clk) begin
        if (clr) begin
            edges    = 0;
            s_digits = 16'h0;
            s_dp     = 4'h0;
            s_blank  = 4'hF;
            s_blink  = 4'h0;
            s_lz     = 1'b0;
        end else begin
            m_p     = edges % SLOT;
            m_slot  = (edges / SLOT) % ND;
            m_frame = (edges / FRAME) % (1 << KW);
            m_on    = !s_blank[m_slot]
                   && !(s_blink[m_slot] && m_frame >= (1 << (KW - 1)))
                   && !(s_lz && m_slot >= sig_digits(s_digits))
                   && ((m_p / (SLOT >> BW)) < int'(brightness));
            m_e.an  = m_on ? ~(4'b0001 << m_slot) : 4'hF;
            m_e.seg = m_on ? ~hex_tab[s_digits[4*m_slot +: 4]] : 7'h7F;
            m_e.dp  = !(m_on && s_dp[m_slot]);
            m_e.fd  = ((edges + 1) % FRAME) == 0;
            q.push_back(m_e);
            if (((edges + 1) % FRAME) == 0) begin
                s_digits = digits;
                s_dp     = dp_in;
                s_blank  = blank_in;
                s_blink  = blink_in;
                s_lz     = lz_suppress;
            end
            edges++;
        end
    end

    always @(negedge clk) begin
        if (!clr && q.size() > 0) begin
            c_e = q.pop_front();
            n_checks++;
            if (an !== c_e.an || seg !== c_e.seg || dp !== c_e.dp || frame_done !== c_e.fd) begin
                n_fail++;
                $display("FAIL scan t=%0t an=%b exp %b seg=%b exp %b dp=%b exp %b frame_done=%b exp %b",
                         $time, an, c_e.an, seg, c_e.seg, dp, c_e.dp, frame_done, c_e.fd);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Counts enabled-anode cycles and frame_done pulses over n cycles
    task automatic measure(input int n, output int on_cnt, output int fd_cnt);
        on_cnt = 0;
        fd_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (an != 4'hF) on_cnt++;
            if (frame_done) fd_cnt++;
        end
    endtask

    int on_cnt, fd_cnt;
    logic found;

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        run(3);
        @(negedge clk);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1);
        check("reset_frame_done", frame_done, 0);

        #1;
        digits = 16'h1234;
        brightness = 2'd3;
        clr = 1'b0;
        measure(FRAME - 1, on_cnt, fd_cnt);
        check("dark_first_frame", on_cnt, 0);
        run(2 * FRAME);

        at_neg();
        measure(2 * FRAME, on_cnt, fd_cnt);
        check("frame_done_rate", fd_cnt, 2);

        at_neg();
        digits = 16'h0050;
        lz_suppress = 1'b1;
        run(2 * FRAME);
        at_neg();
        digits = 16'h0000;
        run(2 * FRAME);
        at_neg();
        lz_suppress = 1'b0;
        run(2 * FRAME);

        at_neg();
        digits = 16'h8888;
        brightness = 2'd1;
        run(2 * FRAME);
        measure(FRAME, on_cnt, fd_cnt);
        check("bright1_on_cycles", on_cnt, ND * 4);
        at_neg();
        brightness = 2'd0;
        measure(FRAME, on_cnt, fd_cnt);
        check("bright0_on_cycles", on_cnt, 0);

        at_neg();
        brightness = 2'd3;
        digits = 16'h1234;
        dp_in = 4'b0101;
        blink_in = 4'b0001;
        blank_in = 4'b0010;
        run(9 * FRAME);

        at_neg();
        digits = 16'h9876;
        run(2 * FRAME);

        for (int k = 0; k < 30; k++) begin
            at_neg();
            digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in = 4'($urandom);
            blank_in = 4'($urandom) & 4'($urandom);
            blink_in = 4'($urandom);
            lz_suppress = 1'($urandom);
            brightness = 2'($urandom);
            run($urandom_range(1, 150));
        end

        at_neg();
        digits = 16'h4321;
        blank_in = 4'h0;
        blink_in = 4'h0;
        brightness = 2'd3;
        found = 1'b0;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            @(posedge clk);
            #2;
            if (an != 4'hF) found = 1'b1;
        end
        check("lit_before_clr", int'(found), 1);
        clr = 1'b1;
        q.delete();
        #1;
        check("async_clr_an", an, 4'hF);
        check("async_clr_seg", seg, 7'h7F);
        check("async_clr_frame_done", frame_done, 0);
        run(3);
        at_neg();
        clr = 1'b0;
        run(3 * FRAME);

        at_neg();
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
